keymux_stream: RTL and testbench



---
 rtl/keymux_stream_if.sv | 22 ++
 rtl/keymux_stream.sv | 73 +++++++
 tb/tb_keymux_stream.sv | 133 +++++++++++++
 3 files changed

// File: rtl/keymux_stream_if.sv
// keymux_stream_if: producer-side and consumer-side stream signals of the keyed stream mux
interface keymux_stream_if #(
    parameter int NR_CH = 4,
    parameter int KEY_LEN = 2,
    parameter int DATA_LEN = 8
);
    logic [NR_CH-1:0] in_valid;
    logic [NR_CH*DATA_LEN-1:0] in_data;
    logic [NR_CH-1:0] in_ready;
    logic out_valid;
    logic [DATA_LEN-1:0] out_data;
    logic [KEY_LEN-1:0] out_ch;
    logic out_ready;
    modport master (
        output in_valid, in_data, out_ready,
        input in_ready, out_valid, out_data, out_ch
    );
    modport slave (
        input in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/keymux_stream.sv
// keymux_stream: registered N-channel stream mux with keyed or round-robin selection
module keymux_stream #(
    parameter int NR_CH = 4,
    parameter int KEY_LEN = 2,
    parameter int DATA_LEN = 8,
    parameter int CNT_LEN = 16
) (
    input logic clk,
    input logic rst_n,
    keymux_stream_if.slave s,
    input logic mode,
    input logic [KEY_LEN-1:0] sel,
    output logic sel_err,
    output logic [CNT_LEN-1:0] xfer_cnt
);
    logic [KEY_LEN-1:0] rr_ptr, gidx, idx;
    logic [KEY_LEN:0] j;
    logic gv, can_load, key_bad, take;
    assign can_load = !s.out_valid || s.out_ready;
    assign key_bad = !mode && ({1'b0, sel} >= (KEY_LEN+1)'(NR_CH));
    assign take = gv && can_load;
    // grant: explicit key, or first valid channel scanning upward from rr_ptr
    always_comb begin
        gv = 1'b0;
        gidx = '0;
        j = '0;
        idx = '0;
        if (!mode) begin
            gv = !key_bad && s.in_valid[sel];
            gidx = sel;
        end else begin
            for (int k = NR_CH - 1; k >= 0; k--) begin
                j = {1'b0, rr_ptr} + (KEY_LEN+1)'(k);
                j = j >= (KEY_LEN+1)'(NR_CH) ? j - (KEY_LEN+1)'(NR_CH) : j;
                idx = j[KEY_LEN-1:0];
                if (s.in_valid[idx]) begin
                    gv = 1'b1;
                    gidx = idx;
                end
            end
        end
    end
    // only the granted channel sees ready, and only when the register can take a beat
    always_comb begin
        s.in_ready = '0;
        s.in_ready[gidx] = take;
    end
    // output register, round-robin pointer, sticky key error and handshake counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.out_valid <= 1'b0;
            s.out_data <= '0;
            s.out_ch <= '0;
            rr_ptr <= '0;
            sel_err <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            if (take) begin
                s.out_valid <= 1'b1;
                s.out_data <= s.in_data[gidx*DATA_LEN +: DATA_LEN];
                s.out_ch <= gidx;
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end
            if (take && mode)
                rr_ptr <= gidx == KEY_LEN'(NR_CH - 1) ? '0 : gidx + 1'b1;
            if (s.out_valid && s.out_ready)
                xfer_cnt <= xfer_cnt + 1'b1;
            if (key_bad)
                sel_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_keymux_stream.sv
// tb_keymux_stream: directed checks of keyed, round-robin, backpressure, key miss, wrap and async reset
module tb_keymux_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode_a, mode_b, err_a, err_b;
    logic [1:0] sel_a, sel_b;
    logic [3:0] cnt_a;
    logic [15:0] cnt_b;
    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] rr_seq[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] pair_seq[4] = '{2'd3, 2'd1, 2'd3, 2'd1};

    keymux_stream_if #(.NR_CH(4), .KEY_LEN(2), .DATA_LEN(8)) ifa ();
    keymux_stream_if #(.NR_CH(3), .KEY_LEN(2), .DATA_LEN(8)) ifb ();

    keymux_stream #(.NR_CH(4), .KEY_LEN(2), .DATA_LEN(8), .CNT_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(ifa), .mode(mode_a), .sel(sel_a),
        .sel_err(err_a), .xfer_cnt(cnt_a)
    );
    keymux_stream #(.NR_CH(3), .KEY_LEN(2), .DATA_LEN(8), .CNT_LEN(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(ifb), .mode(mode_b), .sel(sel_b),
        .sel_err(err_b), .xfer_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        mode_a = 1'b0; sel_a = 2'd0; mode_b = 1'b0; sel_b = 2'd0;
        ifa.in_valid = '0; ifa.in_data = 32'h44A52211; ifa.out_ready = 1'b0;
        ifb.in_valid = '0; ifb.in_data = 24'h332211; ifb.out_ready = 1'b0;
        #1;
        check("rst_valid", 32'(ifa.out_valid), 0);
        check("rst_data", 32'(ifa.out_data), 0);
        check("rst_ch", 32'(ifa.out_ch), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_cnt", 32'(cnt_a), 0);
        #11 rst_n = 1'b1;
        tick;
        mode_a = 1'b0; sel_a = 2'd2; ifa.in_valid = 4'b1111; ifa.out_ready = 1'b1;
        #1 check("key_ready", 32'(ifa.in_ready), 32'b0100);
        tick;
        check("key_valid", 32'(ifa.out_valid), 1);
        check("key_data", 32'(ifa.out_data), 32'hA5);
        check("key_ch", 32'(ifa.out_ch), 2);
        check("key_cnt0", 32'(cnt_a), 0);
        tick;
        check("key_cnt1", 32'(cnt_a), 1);
        tick;
        check("key_cnt2", 32'(cnt_a), 2);
        mode_a = 1'b1;
        #1 check("rr_ready", 32'(ifa.in_ready), 32'b0001);
        for (int i = 0; i < 6; i++) begin
            tick;
            check("rr_ch", 32'(ifa.out_ch), 32'(rr_seq[i]));
        end
        check("rr_data", 32'(ifa.out_data), 32'h22);
        check("rr_cnt", 32'(cnt_a), 8);
        ifa.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("pair_ch", 32'(ifa.out_ch), 32'(pair_seq[i]));
        end
        check("pair_cnt", 32'(cnt_a), 12);
        ifa.out_ready = 1'b0;
        #1 check("bp_ready0", 32'(ifa.in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp_data", 32'(ifa.out_data), 32'h22);
            check("bp_ch", 32'(ifa.out_ch), 1);
            check("bp_ready", 32'(ifa.in_ready), 0);
            check("bp_cnt", 32'(cnt_a), 12);
        end
        ifa.out_ready = 1'b1;
        #1 check("bp_release", 32'(ifa.in_ready), 32'b1000);
        tick;
        check("bp_valid", 32'(ifa.out_valid), 1);
        check("bp_ch3", 32'(ifa.out_ch), 3);
        check("bp_data3", 32'(ifa.out_data), 32'h44);
        check("bp_cnt13", 32'(cnt_a), 13);
        for (int i = 0; i < 3; i++) tick;
        check("wrap_cnt0", 32'(cnt_a), 0);
        tick;
        check("wrap_cnt1", 32'(cnt_a), 1);
        tick;
        check("pre_rst_ch", 32'(ifa.out_ch), 1);
        check("pre_rst_valid", 32'(ifa.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ifa.out_valid), 0);
        check("arst_ch", 32'(ifa.out_ch), 0);
        check("arst_cnt", 32'(cnt_a), 0);
        check("arst_err", 32'(err_a), 0);
        ifa.in_valid = 4'b1111;
        #1 check("arst_ready", 32'(ifa.in_ready), 32'b0001);
        #1 rst_n = 1'b1;
        tick;
        check("arst_first_valid", 32'(ifa.out_valid), 1);
        check("arst_first_data", 32'(ifa.out_data), 32'h11);
        check("arst_first_ch", 32'(ifa.out_ch), 0);
        mode_b = 1'b0; sel_b = 2'd3; ifb.in_valid = 3'b111; ifb.out_ready = 1'b1;
        #1;
        check("miss_err0", 32'(err_b), 0);
        check("miss_ready", 32'(ifb.in_ready), 0);
        tick;
        check("miss_err1", 32'(err_b), 1);
        check("miss_valid", 32'(ifb.out_valid), 0);
        sel_b = 2'd0;
        #1 check("miss_resume_ready", 32'(ifb.in_ready), 32'b001);
        tick;
        check("miss_sticky", 32'(err_b), 1);
        check("miss_out_valid", 32'(ifb.out_valid), 1);
        check("miss_out_data", 32'(ifb.out_data), 32'h11);
        check("miss_out_ch", 32'(ifb.out_ch), 0);
        check("miss_cnt", 32'(cnt_b), 0);
        check("a_err_clear", 32'(err_a), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
